// File: rtl/clic_gateway.sv
// Interrupt gateway: per-source synchroniser, polarity fix-up and level/edge
// pending-bit generation feeding the target stage ip input.

module clic_gateway_lane #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic le_i,
    input  logic pol_i,
    input  logic claim_i,
    input  logic sw_hit_i,
    input  logic sw_wdata_i,
    output logic ip_o
);
    logic s;
    logic a;
    logic prev_q;
    logic ip_q;
    logic edge_det;

    if (SyncStages == 0) begin : g_nosync
        assign s = src_i;
    end else if (SyncStages == 1) begin : g_sync1
        logic sync_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) sync_q <= 1'b0;
            else         sync_q <= src_i;
        end
        assign s = sync_q;
    end else begin : g_syncn
        logic [SyncStages-1:0] sync_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) sync_q <= '0;
            else         sync_q <= {sync_q[SyncStages-2:0], src_i};
        end
        assign s = sync_q[SyncStages-1];
    end

    assign a        = s ^ pol_i;
    assign edge_det = a & ~prev_q;

    // Edge set outranks software write, which outranks claim, so an edge
    // coinciding with a claim is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            ip_q   <= 1'b0;
        end else begin
            prev_q <= a;
            if (!le_i)         ip_q <= a;
            else if (edge_det) ip_q <= 1'b1;
            else if (sw_hit_i) ip_q <= sw_wdata_i;
            else if (claim_i)  ip_q <= 1'b0;
        end
    end

    assign ip_o = ip_q;
endmodule

module clic_gateway #(
    parameter int unsigned N_SOURCE   = 256,
    parameter int unsigned SyncStages = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_SOURCE-1:0]         src_i,
    input  logic [N_SOURCE-1:0]         le_i,
    input  logic [N_SOURCE-1:0]         pol_i,
    input  logic [N_SOURCE-1:0]         claim_i,
    input  logic                        sw_we_i,
    input  logic [$clog2(N_SOURCE)-1:0] sw_idx_i,
    input  logic                        sw_wdata_i,
    output logic [N_SOURCE-1:0]         ip_o
);
    localparam int unsigned IW = $clog2(N_SOURCE);

    logic [N_SOURCE-1:0] sw_hit;

    // Indices at or beyond N_SOURCE match no lane and are dropped.
    for (genvar gi = 0; gi < N_SOURCE; gi++) begin : g_lane
        assign sw_hit[gi] = sw_we_i && (sw_idx_i == IW'(gi));

        clic_gateway_lane #(
            .SyncStages(SyncStages)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .src_i     (src_i[gi]),
            .le_i      (le_i[gi]),
            .pol_i     (pol_i[gi]),
            .claim_i   (claim_i[gi]),
            .sw_hit_i  (sw_hit[gi]),
            .sw_wdata_i(sw_wdata_i),
            .ip_o      (ip_o[gi])
        );
    end
endmodule
